regfile_arbiter: RTL and testbench

REGFILE_ARBITER -- requirements
Module: regfile_arbiter

---
 rtl/regfile_arbiter_if.sv | 47 ++++
 rtl/regfile_arbiter.sv | 136 +++++++++++++
 tb/tb_regfile_arbiter.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_arbiter_if.sv
// Bus bundle between two requesters, the arbiter and the register file.
// The arbiter connects through the slave modport. Requesters and the
// register file sit on the master side.
interface regfile_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  // Requester A
  logic                  a_req;
  logic                  a_we;
  logic                  a_lock;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [DATA_WIDTH-1:0] a_wdata;
  logic                  a_ack;
  logic [DATA_WIDTH-1:0] a_rdata;
  // Requester B
  logic                  b_req;
  logic                  b_we;
  logic                  b_lock;
  logic [ADDR_WIDTH-1:0] b_addr;
  logic [DATA_WIDTH-1:0] b_wdata;
  logic                  b_ack;
  logic [DATA_WIDTH-1:0] b_rdata;
  // Register-file side
  logic [ADDR_WIDTH-1:0] rf_address;
  logic [DATA_WIDTH-1:0] rf_data;
  logic                  rf_write_en;
  logic [DATA_WIDTH-1:0] rf_rdata;
  // Status
  logic                  busy;

  modport slave (
    input  a_req, a_we, a_lock, a_addr, a_wdata,
    input  b_req, b_we, b_lock, b_addr, b_wdata,
    input  rf_rdata,
    output a_ack, a_rdata, b_ack, b_rdata,
    output rf_address, rf_data, rf_write_en, busy
  );

  modport master (
    output a_req, a_we, a_lock, a_addr, a_wdata,
    output b_req, b_we, b_lock, b_addr, b_wdata,
    output rf_rdata,
    input  a_ack, a_rdata, b_ack, b_rdata,
    input  rf_address, rf_data, rf_write_en, busy
  );
endinterface

// File: rtl/regfile_arbiter.sv
// Two-requester arbiter in front of a single-port register file.
// Every transaction takes three cycles: IDLE (accept), ACCESS (register-file
// access) and DONE (ack). Grants alternate round-robin between the two
// requesters. A locked requester may win up to four grants in a row.
module regfile_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  regfile_arbiter_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t                state_q;
  logic                  id_q;          // 0 = A, 1 = B for the in-flight transaction
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  wr_en_q;
  logic                  ack_a_q;
  logic                  ack_b_q;
  logic                  busy_q;
  logic                  last_grant_q;
  logic                  last_lock_q;   // lock value of the previous grant
  logic [1:0]            lock_cnt_q;

  logic                  win_d;
  logic                  win_we_d;
  logic                  win_lock_d;
  logic [ADDR_WIDTH-1:0] win_addr_d;
  logic [DATA_WIDTH-1:0] win_wdata_d;
  logic [1:0]            lock_cnt_d;

  // Choose the winner for a possible acceptance this cycle and its lock count.
  always_comb begin
    // NOTE: every always_comb output is assigned a default first, so no path can infer a latch.
    win_d      = 1'b0;
    lock_cnt_d = 2'd0;
    if (bus.a_req && bus.b_req) begin
      // A locked previous owner keeps the bus until it has been re-granted three times.
      if (last_lock_q && (lock_cnt_q != 2'd3)) begin
        win_d = last_grant_q;
      end else begin
        win_d = ~last_grant_q;
      end
    end else begin
      win_d = bus.b_req;
    end

    win_we_d    = win_d ? bus.b_we    : bus.a_we;
    win_lock_d  = win_d ? bus.b_lock  : bus.a_lock;
    win_addr_d  = win_d ? bus.b_addr  : bus.a_addr;
    win_wdata_d = win_d ? bus.b_wdata : bus.a_wdata;

    // The count saturates at 3 and never wraps.
    if ((win_d == last_grant_q) && win_lock_d) begin
      lock_cnt_d = (lock_cnt_q == 2'd3) ? 2'd3 : lock_cnt_q + 2'd1;
    end
  end

  // Transaction FSM. All outputs are registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      id_q         <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      wr_en_q      <= 1'b0;
      ack_a_q      <= 1'b0;
      ack_b_q      <= 1'b0;
      busy_q       <= 1'b0;
      last_grant_q <= 1'b1;
      last_lock_q  <= 1'b0;
      lock_cnt_q   <= 2'd0;
    end else begin
      // NOTE: state is updated with non-blocking assignments, so every register samples pre-edge values.
      case (state_q)
        IDLE: begin
          if (bus.a_req || bus.b_req) begin
            state_q      <= ACCESS;
            id_q         <= win_d;
            we_q         <= win_we_d;
            addr_q       <= win_addr_d;
            wdata_q      <= win_wdata_d;
            wr_en_q      <= win_we_d;
            busy_q       <= 1'b1;
            last_grant_q <= win_d;
            last_lock_q  <= win_lock_d;
            lock_cnt_q   <= lock_cnt_d;
          end
        end
        ACCESS: begin
          state_q <= DONE;
          wr_en_q <= 1'b0;
          if (!we_q) begin
            rdata_q <= bus.rf_rdata;
          end
          ack_a_q <= ~id_q;
          ack_b_q <= id_q;
        end
        DONE: begin
          state_q <= IDLE;
          ack_a_q <= 1'b0;
          ack_b_q <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          wr_en_q <= 1'b0;
          ack_a_q <= 1'b0;
          ack_b_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rf_address  = addr_q;
  assign bus.rf_data     = wdata_q;
  assign bus.rf_write_en = wr_en_q;
  assign bus.a_ack       = ack_a_q;
  assign bus.b_ack       = ack_b_q;
  assign bus.a_rdata     = rdata_q;
  assign bus.b_rdata     = rdata_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Testbench for regfile_arbiter. The bench provides a 16x8 register file
// behind the DUT. It checks a table of single transactions, hand-written
// contention, lock and reset sequences, and random rounds against a
// transaction-level model.
module tb_regfile_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;

  regfile_arbiter_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus ();

  regfile_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Register file seen by the DUT: combinational read, write on the rising edge.
  logic [7:0] mem [16] = '{default: 8'h00};
  assign bus.rf_rdata = mem[bus.rf_address];
  always @(posedge clk) begin
    if (bus.rf_write_en) mem[bus.rf_address] <= bus.rf_data;
  end

  int total = 0;
  int bad   = 0;

  // Reference model: expected register-file contents, read-data register and arbitration history.
  logic [7:0] mmem [16] = '{default: 8'h00};
  logic [7:0] m_rdata;
  bit         m_last;
  bit         m_lock;
  int         m_cnt;

  typedef struct {
    bit         we;
    bit         lock;
    logic [3:0] addr;
    logic [7:0] wdata;
  } txn_t;

  typedef struct {
    bit         who;
    bit         we;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rd;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_last  = 1'b1;
    m_lock  = 1'b0;
    m_cnt   = 0;
    m_rdata = 8'h00;
  endtask

  // Arbitration rules: a single requester always wins. With two requesters,
  // a locked previous owner with fewer than 3 repeats wins again; otherwise
  // the side that did not win last time wins.
  task automatic model_grant(input bit ra, input bit rb, input bit la, input bit lb, output bit w);
    bit lk;
    if (ra && rb) w = (m_lock && m_cnt < 3) ? m_last : !m_last;
    else          w = rb;
    lk = w ? lb : la;
    if (w == m_last && lk) m_cnt = (m_cnt == 3) ? 3 : m_cnt + 1;
    else                   m_cnt = 0;
    m_last = w;
    m_lock = lk;
  endtask

  task automatic model_xfer(input txn_t t, output logic [7:0] rd);
    if (t.we) mmem[t.addr] = t.wdata;
    else      m_rdata = mmem[t.addr];
    rd = m_rdata;
  endtask

  task automatic drive(input bit who, input bit req, input bit we, input bit lock,
                       input logic [3:0] addr, input logic [7:0] wdata);
    if (!who) begin
      bus.a_req = req; bus.a_we = we; bus.a_lock = lock; bus.a_addr = addr; bus.a_wdata = wdata;
    end else begin
      bus.b_req = req; bus.b_we = we; bus.b_lock = lock; bus.b_addr = addr; bus.b_wdata = wdata;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
    @(negedge clk);
    @(negedge clk);
    check("reset_busy",  bus.busy, 0);
    check("reset_a_ack", bus.a_ack, 0);
    check("reset_b_ack", bus.b_ack, 0);
    check("reset_wen",   bus.rf_write_en, 0);
    check("reset_addr",  bus.rf_address, 0);
    check("reset_data",  bus.rf_data, 0);
    check("reset_rdata", bus.a_rdata, 0);
    model_reset();
    rst = 1'b0;
  endtask

  // A single transaction from one requester, checked cycle by cycle.
  task automatic single(input bit who, input bit we, input logic [3:0] addr,
                        input logic [7:0] wdata, input logic [7:0] exp_rd);
    txn_t       t;
    logic [7:0] mrd;
    @(negedge clk);
    drive(who, 1'b1, we, 1'b0, addr, wdata);
    @(posedge clk); #1;
    check("acc_busy",  bus.busy, 1);
    check("acc_wen",   bus.rf_write_en, we);
    check("acc_addr",  bus.rf_address, addr);
    if (we) check("acc_data", bus.rf_data, wdata);
    check("acc_noack", bus.a_ack | bus.b_ack, 0);
    @(posedge clk); #1;
    check("done_wen",   bus.rf_write_en, 0);
    check("done_ack",   who ? bus.b_ack : bus.a_ack, 1);
    check("done_other", who ? bus.a_ack : bus.b_ack, 0);
    check("done_rdata", who ? bus.b_rdata : bus.a_rdata, exp_rd);
    drive(who, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
    @(posedge clk); #1;
    check("idle_busy", bus.busy, 0);
    check("idle_ack",  bus.a_ack | bus.b_ack, 0);
    t = '{we: we, lock: 1'b0, addr: addr, wdata: wdata};
    model_xfer(t, mrd);
  endtask

  // One or two requesters raise a request together. Each drops its request
  // once acked, and the model predicts the grant order and data.
  task automatic round(input bit ra, input bit rb, input txn_t ta, input txn_t tb_t, output bit first);
    bit         exp_who [2];
    logic [7:0] exp_rd [2];
    int         need;
    int         got;
    bit         w;
    first = 1'b0;
    need  = (ra && rb) ? 2 : 1;
    model_grant(ra, rb, ta.lock, tb_t.lock, w);
    exp_who[0] = w;
    model_xfer(w ? tb_t : ta, exp_rd[0]);
    if (need == 2) begin
      model_grant(w, !w, ta.lock, tb_t.lock, w);
      exp_who[1] = w;
      model_xfer(w ? tb_t : ta, exp_rd[1]);
    end
    @(negedge clk);
    if (ra) drive(1'b0, 1'b1, ta.we, ta.lock, ta.addr, ta.wdata);
    if (rb) drive(1'b1, 1'b1, tb_t.we, tb_t.lock, tb_t.addr, tb_t.wdata);
    got = 0;
    for (int cyc = 1; cyc <= 12 && got < need; cyc++) begin
      @(negedge clk);
      if (bus.a_ack || bus.b_ack) begin
        w = bus.b_ack;
        check("grant_order", w, exp_who[got]);
        check("one_ack",     bus.a_ack & bus.b_ack, 0);
        check("ack_cycle",   cyc, (got == 0) ? 2 : 5);
        check("rdata",       w ? bus.b_rdata : bus.a_rdata, exp_rd[got]);
        if (got == 0) first = w;
        drive(w, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
        got++;
      end
    end
    if (got != need) check("ack_timeout", got, need);
  endtask

  // Both requesters hold req high (reads). The order of the first n grants
  // is compared with exp_order, where bit i is the winner of grant i (1 = B).
  task automatic stream(input int n, input bit la, input bit lb,
                        input logic [15:0] exp_order, input string tag);
    int got;
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, la, 4'h1, 8'h00);
    drive(1'b1, 1'b1, 1'b0, lb, 4'h2, 8'h00);
    got = 0;
    for (int cyc = 0; cyc < 3 * n + 12 && got < n; cyc++) begin
      @(negedge clk);
      if (bus.a_ack || bus.b_ack) begin
        check({tag, "_order"}, bus.b_ack, exp_order[got]);
        check({tag, "_one_ack"}, bus.a_ack & bus.b_ack, 0);
        got++;
        if (got == n) begin
          drive(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
          drive(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
        end
      end
    end
    if (got != n) check({tag, "_timeout"}, got, n);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t       vecs [8];
    txn_t       ta;
    txn_t       tb_t;
    bit         first;
    logic [1:0] rq;

    // Single transactions. A write expects the read-data register left at the previous read value.
    vecs[0] = '{1'b0, 1'b1, 4'h3, 8'h5A, 8'h00};
    vecs[1] = '{1'b0, 1'b0, 4'h3, 8'h00, 8'h5A};
    vecs[2] = '{1'b1, 1'b0, 4'h3, 8'h00, 8'h5A};
    vecs[3] = '{1'b1, 1'b1, 4'hF, 8'hC3, 8'h5A};
    vecs[4] = '{1'b0, 1'b0, 4'hF, 8'h00, 8'hC3};
    vecs[5] = '{1'b1, 1'b1, 4'h0, 8'h01, 8'hC3};
    vecs[6] = '{1'b1, 1'b0, 4'h0, 8'h00, 8'h01};
    vecs[7] = '{1'b0, 1'b0, 4'h7, 8'h00, 8'h00};

    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
    do_reset();
    for (int i = 0; i < 8; i++) begin
      single(vecs[i].who, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rd);
    end

    // Contention right after reset: A wins first, and B is acked three cycles later.
    do_reset();
    ta   = '{we: 1'b1, lock: 1'b0, addr: 4'h4, wdata: 8'h44};
    tb_t = '{we: 1'b1, lock: 1'b0, addr: 4'h5, wdata: 8'h55};
    round(1'b1, 1'b1, ta, tb_t, first);
    check("contention_first", first, 0);

    // Round-robin with both requesting continuously: A,B,A,B,A,B.
    do_reset();
    stream(6, 1'b0, 1'b0, 16'b0000_0000_0010_1010, "rr");

    // Lock cap: A,A,A,A,B. After B, the count restarts and A wins four more grants.
    do_reset();
    stream(10, 1'b1, 1'b0, 16'b0000_0010_0001_0000, "lock");

    // Reset while an ACCESS write of 0xFF to address 7 is in flight.
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 4'h7, 8'hFF);
    @(posedge clk); #1;
    check("mid_wen_before", bus.rf_write_en, 1);
    #2 rst = 1'b1;
    #1;
    check("mid_wen_drop", bus.rf_write_en, 0);
    check("mid_busy",     bus.busy, 0);
    check("mid_no_ack",   bus.a_ack | bus.b_ack, 0);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
    @(posedge clk); #1;
    check("mid_mem7", mem[7], mmem[7]);
    @(negedge clk);
    model_reset();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_reset_no_ack", bus.a_ack | bus.b_ack, 0);
    end
    single(1'b0, 1'b0, 4'h7, 8'h00, mmem[7]);

    // Random rounds against the model.
    do_reset();
    for (int r = 0; r < 80; r++) begin
      rq         = 2'($urandom_range(1, 3));
      ta.we      = 1'($urandom);
      ta.lock    = 1'($urandom);
      ta.addr    = 4'($urandom);
      ta.wdata   = 8'($urandom);
      tb_t.we    = 1'($urandom);
      tb_t.lock  = 1'($urandom);
      tb_t.addr  = 4'($urandom);
      tb_t.wdata = 8'($urandom);
      round(rq[0], rq[1], ta, tb_t, first);
    end

    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      check("final_mem", mem[i], mmem[i]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
